// File: rtl/dmem_arb_pkg.sv
// Shared encodings and sizes for the data-memory arbiter.
// Optional build macro used by the top: DMEM_ARB_PERF_EN.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_DMA  = 2'd2
  } state_t;

  localparam int DEF_IO_BIT = 10;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/dmem_arb_port_mux.sv
// Steers the granted requester onto the RAM/IO bus, decodes IO versus RAM,
// and returns read data only to the requester that owns the current access.
module dmem_arb_port_mux
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int IO_BIT = DEF_IO_BIT
) (
  input  state_t              grant,
  input  logic                c_req,
  input  logic                c_we,
  input  logic [ADDR_W:0]     c_addr,
  input  logic [31:0]         c_wdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W:0]     d_addr,
  input  logic [31:0]         d_wdata,
  input  logic [31:0]         mem_spo,
  input  logic [31:0]         io_din,
  output logic                c_ack,
  output logic [31:0]         c_rdata,
  output logic                d_ack,
  output logic [31:0]         d_rdata,
  output logic [ADDR_W-3:0]   mem_a,
  output logic [31:0]         mem_d,
  output logic                mem_we,
  output logic [7:0]          io_addr,
  output logic [31:0]         io_dout,
  output logic                io_we
);

  logic              c_sel;
  logic              d_sel;
  logic              we;
  logic [ADDR_W:0]   addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;

  assign c_sel = (grant == ST_CPU) && c_req;
  assign d_sel = (grant == ST_DMA) && d_req;

  always_comb begin
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    if (c_sel) begin
      we    = c_we;
      addr  = c_addr;
      wdata = c_wdata;
    end else if (d_sel) begin
      we    = d_we;
      addr  = d_addr;
      wdata = d_wdata;
    end
  end

  // An idle or withdrawn grant leaves addr/wdata/we at zero, so the bus idles at 0.
  always_comb begin
    mem_a   = addr[ADDR_W-1:2];
    mem_d   = '0;
    mem_we  = 1'b0;
    io_addr = '0;
    io_dout = '0;
    io_we   = 1'b0;
    rdata   = mem_spo;
    if (addr[IO_BIT]) begin
      io_addr = addr[7:0];
      io_dout = wdata;
      io_we   = we;
      rdata   = io_din;
    end else begin
      mem_d   = wdata;
      mem_we  = we;
    end
  end

  assign c_ack   = c_sel;
  assign d_ack   = d_sel;
  assign c_rdata = c_sel ? rdata : 32'd0;
  assign d_rdata = d_sel ? rdata : 32'd0;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter (CPU MEM stage, DMA loader) for the data RAM and IO window.
// Define DMEM_ARB_PERF_EN to add the stall/grant performance counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int IO_BIT    = DEF_IO_BIT,
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W:0]   c_addr,
  input  logic [31:0]       c_wdata,
  output logic              c_ack,
  output logic [31:0]       c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_lock,
  input  logic [ADDR_W:0]   d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-3:0] mem_a,
  output logic [31:0]       mem_d,
  output logic              mem_we,
  input  logic [31:0]       mem_spo,
  output logic [7:0]        io_addr,
  output logic [31:0]       io_dout,
  output logic              io_we,
  input  logic [31:0]       io_din,
`ifdef DMEM_ARB_PERF_EN
  output logic [31:0]       perf_cstall,
  output logic [31:0]       perf_dgrant,
`endif
  output logic [1:0]        dbg_state
);

  // Handshake: a requester holds x_req (and its address/data) until it sees
  // x_ack in the same cycle; each cycle with x_req & x_ack is one access.

  state_t             state;
  state_t             nxt;
  logic [CNT_W-1:0]   wait_cnt;
  logic [CNT_W-1:0]   beat_cnt;
  logic               starve;
  logic               lock_hold;

  // The counters are registered, so a DMA ack this cycle already counts:
  // the starved DMA is not re-forced and the final locked beat ends the lock.
  assign starve    = d_req && (int'(wait_cnt) == MAX_WAIT) && !d_ack;
  assign lock_hold = (state == ST_DMA) && d_req && d_lock &&
                     ((int'(beat_cnt) + 1) < BURST_MAX);

  always_comb begin
    nxt = ST_IDLE;
    if (starve)         nxt = ST_DMA;
    else if (lock_hold) nxt = ST_DMA;
    else if (c_req)     nxt = ST_CPU;
    else if (d_req)     nxt = ST_DMA;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      beat_cnt <= '0;
    end else begin
      state <= nxt;
      if (!d_req || d_ack)
        wait_cnt <= '0;
      else if (int'(wait_cnt) < MAX_WAIT)
        wait_cnt <= wait_cnt + CNT_W'(1);
      if ((nxt != ST_DMA) || !d_lock)
        beat_cnt <= '0;
      else if (d_ack && (int'(beat_cnt) < BURST_MAX))
        beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

  assign dbg_state = state;

  dmem_arb_port_mux #(
    .ADDR_W (ADDR_W),
    .IO_BIT (IO_BIT)
  ) u_mux (
    .grant   (state),
    .c_req   (c_req),
    .c_we    (c_we),
    .c_addr  (c_addr),
    .c_wdata (c_wdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .mem_spo (mem_spo),
    .io_din  (io_din),
    .c_ack   (c_ack),
    .c_rdata (c_rdata),
    .d_ack   (d_ack),
    .d_rdata (d_rdata),
    .mem_a   (mem_a),
    .mem_d   (mem_d),
    .mem_we  (mem_we),
    .io_addr (io_addr),
    .io_dout (io_dout),
    .io_we   (io_we)
  );

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cstall <= '0;
      perf_dgrant <= '0;
    end else begin
      if (c_req && !c_ack) perf_cstall <= perf_cstall + 32'd1;
      if (d_ack)           perf_dgrant <= perf_dgrant + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: RAM model, IO stub, read-data scoreboard.
module tb_dmem_arbiter;

  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst;
  logic              c_req, c_we, d_req, d_we, d_lock;
  logic [ADDR_W:0]   c_addr, d_addr;
  logic [31:0]       c_wdata, d_wdata;
  logic              c_ack, d_ack;
  logic [31:0]       c_rdata, d_rdata;
  logic [ADDR_W-3:0] mem_a;
  logic [31:0]       mem_d, mem_spo;
  logic              mem_we;
  logic [7:0]        io_addr;
  logic [31:0]       io_dout, io_din;
  logic              io_we;
  logic [1:0]        dbg_state;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0]       perf_cstall, perf_dgrant;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] c_exp_q[$];
  logic [31:0] d_exp_q[$];
  logic [31:0] ram [256];

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .IO_BIT(10), .MAX_WAIT(4), .BURST_MAX(8)
  ) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_spo(mem_spo),
    .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we), .io_din(io_din),
`ifdef DMEM_ARB_PERF_EN
    .perf_cstall(perf_cstall), .perf_dgrant(perf_dgrant),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // RAM model with async read, IO stub
  initial for (int i = 0; i < 256; i++) ram[i] = 32'd0;
  always @(posedge clk) if (mem_we) ram[mem_a] <= mem_d;
  assign mem_spo = ram[mem_a];
  assign io_din  = 32'h0000_1234;

  // scoreboard: pop expected load data on every read ack
  always @(negedge clk) begin
    logic [31:0] exp;
    if (rst && c_ack && !c_we) begin
      n_assert++;
      if (c_exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL c_sb_unexpected: c_rdata=%h with no expected entry", c_rdata);
      end else begin
        exp = c_exp_q.pop_front();
        if (c_rdata !== exp) begin
          n_fail++;
          $display("FAIL c_sb_rdata: got %h expected %h", c_rdata, exp);
        end
      end
    end
    if (rst && d_ack && !d_we) begin
      n_assert++;
      if (d_exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL d_sb_unexpected: d_rdata=%h with no expected entry", d_rdata);
      end else begin
        exp = d_exp_q.pop_front();
        if (d_rdata !== exp) begin
          n_fail++;
          $display("FAIL d_sb_rdata: got %h expected %h", d_rdata, exp);
        end
      end
    end
    if (c_ack && d_ack) begin
      n_fail++;
      $display("FAIL both_ack: c_ack=%b d_ack=%b expected not both 1", c_ack, d_ack);
    end
    if (mem_we && io_we) begin
      n_fail++;
      $display("FAIL both_we: mem_we=%b io_we=%b expected not both 1", mem_we, io_we);
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    c_req = 0; c_we = 0; d_req = 0; d_we = 0; d_lock = 0;
    repeat (n) cyc();
  endtask

  task automatic test_reset();
    rst = 0; c_req = 1; c_we = 1; c_addr = 11'h010; c_wdata = 32'hFFFF_FFFF;
    d_req = 0; d_we = 0; d_lock = 0; d_addr = '0; d_wdata = '0;
    repeat (3) cyc();
    @(negedge clk);
    n_assert++;
    if ({c_ack, d_ack, mem_we, io_we} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_ctrl: ack/we=%b expected 0000", {c_ack, d_ack, mem_we, io_we});
    end
    n_assert++;
    if ({mem_a, mem_d, io_addr, io_dout} !== '0) begin
      n_fail++; $display("FAIL rst_bus: mem_a=%h mem_d=%h io_addr=%h io_dout=%h expected 0", mem_a, mem_d, io_addr, io_dout);
    end
    n_assert++;
    if ({c_rdata, d_rdata} !== 64'd0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL rst_rdata_state: c_rdata=%h d_rdata=%h state=%0d expected 0", c_rdata, d_rdata, dbg_state);
    end
    cyc();
    rst = 1; c_wdata = 32'd0;
    cyc();
    @(negedge clk);
    n_assert++;
    if (c_ack !== 1'b1 || dbg_state !== 2'd1) begin
      n_fail++; $display("FAIL rst_release: c_ack=%b state=%0d expected 1/1", c_ack, dbg_state);
    end
    cyc();
    idle(2);
  endtask

  task automatic test_cpu_mem();
    c_req = 1; c_we = 1; c_addr = 11'h010; c_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_assert++;
    if (c_ack !== 1'b0) begin
      n_fail++; $display("FAIL cpu_latency: c_ack=%b before grant, expected 0", c_ack);
    end
    cyc();
    @(negedge clk);
    n_assert++;
    if (c_ack !== 1'b1 || mem_we !== 1'b1 || mem_a !== 8'd4 || mem_d !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL cpu_store: ack=%b we=%b a=%h d=%h expected 1 1 04 deadbeef", c_ack, mem_we, mem_a, mem_d);
    end
    n_assert++;
    if (io_we !== 1'b0) begin
      n_fail++; $display("FAIL cpu_store_io_we: io_we=%b expected 0", io_we);
    end
    cyc();
    c_we = 0; c_exp_q.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    n_assert++;
    if (c_ack !== 1'b1 || io_we !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL cpu_load: ack=%b io_we=%b mem_we=%b expected 1 0 0", c_ack, io_we, mem_we);
    end
    cyc();
    idle(2);
  endtask

  task automatic test_dma_read();
    d_req = 1; d_we = 0; d_addr = 11'h010; d_exp_q.push_back(32'hDEAD_BEEF);
    cyc();
    @(negedge clk);
    n_assert++;
    if (d_ack !== 1'b1 || c_ack !== 1'b0 || c_rdata !== 32'd0) begin
      n_fail++; $display("FAIL dma_read: d_ack=%b c_ack=%b c_rdata=%h expected 1 0 0", d_ack, c_ack, c_rdata);
    end
    cyc();
    idle(2);
  endtask

  task automatic test_io();
    c_req = 1; c_we = 1; c_addr = 11'h404; c_wdata = 32'h55;
    cyc();
    @(negedge clk);
    n_assert++;
    if (io_we !== 1'b1 || io_addr !== 8'h04 || io_dout !== 32'h55 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL io_store: io_we=%b io_addr=%h io_dout=%h mem_we=%b expected 1 04 55 0", io_we, io_addr, io_dout, mem_we);
    end
    cyc();
    c_we = 0; c_exp_q.push_back(32'h1234);
    @(negedge clk);
    n_assert++;
    if (c_ack !== 1'b1 || io_we !== 1'b0) begin
      n_fail++; $display("FAIL io_load: c_ack=%b io_we=%b expected 1 0", c_ack, io_we);
    end
    cyc();
    idle(2);
  endtask

  task automatic test_starvation();
    int waited;
    bit got;
    c_req = 1; c_we = 1; c_addr = 11'h020; c_wdata = 32'd1;
    cyc();
    d_req = 1; d_we = 1; d_addr = 11'h030; d_wdata = 32'hA5;
    waited = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (d_ack) begin
        got = 1;
        n_assert++;
        if (c_ack !== 1'b0) begin
          n_fail++; $display("FAIL starve_cack: c_ack=%b in forced DMA cycle, expected 0", c_ack);
        end
      end else begin
        waited++;
        cyc();
      end
    end
    n_assert++;
    if (!got || waited != 5) begin
      n_fail++; $display("FAIL starve_wait: got=%0d waited=%0d expected 1/5", got, waited);
    end
    cyc();
    d_req = 0;
    @(negedge clk);
    n_assert++;
    if (c_ack !== 1'b1 || d_ack !== 1'b0 || ram[12] !== 32'hA5) begin
      n_fail++; $display("FAIL starve_after: c_ack=%b d_ack=%b ram=%h expected 1 0 a5", c_ack, d_ack, ram[12]);
    end
    cyc();
    idle(2);
  endtask

  task automatic test_burst();
    int beats;
    bit done;
    d_req = 1; d_lock = 1; d_we = 1; d_addr = 11'h080; d_wdata = 32'd0;
    cyc();
    c_req = 1; c_we = 1; c_addr = 11'h0C0; c_wdata = 32'h77;
    beats = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (d_ack) begin
        beats++;
        cyc();
        d_addr = d_addr + 11'd4; d_wdata = beats;
        if (beats == 10) d_req = 0;
      end else begin
        done = 1;
        n_assert++;
        if (c_ack !== 1'b1) begin
          n_fail++; $display("FAIL burst_cpu: c_ack=%b after burst, expected 1", c_ack);
        end
      end
    end
    n_assert++;
    if (beats != 8) begin
      n_fail++; $display("FAIL burst_len: beats=%0d expected 8", beats);
    end
    n_assert++;
    if (ram[39] !== 32'd7 || ram[40] !== 32'd0) begin
      n_fail++; $display("FAIL burst_data: ram39=%h ram40=%h expected 7 0", ram[39], ram[40]);
    end
    cyc();
    idle(2);
  endtask

  task automatic test_withdraw();
    c_req = 1; c_we = 1; c_addr = 11'h040; c_wdata = 32'h77;
    cyc();
    @(negedge clk);
    n_assert++;
    if (c_ack !== 1'b1) begin
      n_fail++; $display("FAIL wd_grant: c_ack=%b expected 1", c_ack);
    end
    cyc();
    c_req = 0;
    @(negedge clk);
    n_assert++;
    if (dbg_state !== 2'd1 || c_ack !== 1'b0 || mem_we !== 1'b0 || mem_a !== 8'd0 || mem_d !== 32'd0) begin
      n_fail++; $display("FAIL wd_bus: state=%0d ack=%b we=%b a=%h d=%h expected 1 0 0 0 0", dbg_state, c_ack, mem_we, mem_a, mem_d);
    end
    cyc();
    @(negedge clk);
    n_assert++;
    if (dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL wd_idle: state=%0d expected 0", dbg_state);
    end
    idle(2);
  endtask

  task automatic test_reset_abort();
    c_req = 1; c_we = 1; c_addr = 11'h050; c_wdata = 32'h99;
    cyc();
    rst = 0;
    @(negedge clk);
    n_assert++;
    if (c_ack !== 1'b0 || mem_we !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL abort_out: ack=%b we=%b state=%0d expected 0 0 0", c_ack, mem_we, dbg_state);
    end
    cyc();
    n_assert++;
    if (ram[20] !== 32'd0) begin
      n_fail++; $display("FAIL abort_write: ram20=%h expected 0", ram[20]);
    end
    rst = 1;
    idle(2);
  endtask

  initial begin
    test_reset();
    test_cpu_mem();
    test_dma_read();
    test_io();
    test_starvation();
    test_burst();
    test_withdraw();
    test_reset_abort();
    n_assert++;
    if (c_exp_q.size() != 0 || d_exp_q.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: c_left=%0d d_left=%0d expected 0", c_exp_q.size(), d_exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
